// File: rtl/logdiv_pkg.sv
// Shared constants and payload types for the pipelined Mitchell log-domain divider.
package logdiv_pkg;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned FRAC_W   = WIDTH - 1;
  localparam int unsigned OUT_FRAC = 8;
  localparam int unsigned Q_W      = WIDTH + OUT_FRAC;
  localparam int unsigned K_W      = 4;
  localparam int unsigned E_W      = 5;
  localparam int unsigned M_W      = FRAC_W + 2;
  localparam int unsigned HALF     = WIDTH / 2;
  localparam int unsigned W_W      = Q_W + 2;

  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [FRAC_W-1:0] f;
  } log_t;

  typedef logic [Q_W-1:0] quo_t;

  localparam quo_t Q_SAT = '1;

  // S1 payload: encoded operands plus zero flags
  typedef struct packed {
    log_t la;
    log_t lb;
    logic za;
    logic zb;
  } s1_t;

  // S2 payload: signed exponent and Q2.15 mantissa
  typedef struct packed {
    logic signed [E_W-1:0] e;
    logic [M_W-1:0]        m;
    logic                  za;
    logic                  zb;
  } s2_t;
endpackage

// File: rtl/log_divider_16bit_if.sv
// Operand/result handshake bundle for log_divider_16bit.
interface log_divider_16bit_if;
  import logdiv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  quo_t             q;
  logic             div_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_zero
  );
endinterface

// File: rtl/log_divider_16bit_lod16.sv
// Leading-one detector: returns the log2 integer part and the left-aligned fraction.
module lod16
  import logdiv_pkg::*;
(
  input  logic [WIDTH-1:0] i_x,
  output log_t             o_log,
  output logic             o_zero
);

  logic [K_W-1:0]   w_k;
  logic [WIDTH-1:0] w_sh;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_x[i]) w_k = K_W'(i);
    end
    // shifting the leading one to the MSB leaves the fraction directly below it
    w_sh    = i_x << (K_W'(FRAC_W) - w_k);
    o_log.k = w_k;
    o_log.f = w_sh[FRAC_W-1:0];
    o_zero  = ~|i_x;
  end

endmodule

// File: rtl/log_divider_16bit.sv
// Three-stage Mitchell approximate divider: a/b -> unsigned Q16.8 with div-by-zero flag.
// Optional LOGDIV_ROUND_EN: round half-up at 2^-9 in the antilog stage instead of truncating.
module log_divider_16bit
  import logdiv_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  log_divider_16bit_if.slave bus
);

  logic r_s1_v;
  s1_t  r_s1;
  logic r_s2_v;
  s2_t  r_s2;
  logic r_out_v;
  quo_t r_q;
  logic r_dz;

  logic w_ld1;
  logic w_ld2;
  logic w_ld3;

  // each stage loads when its successor is empty or advancing
  assign w_ld3 = ~r_out_v | bus.out_ready;
  assign w_ld2 = ~r_s2_v  | w_ld3;
  assign w_ld1 = ~r_s1_v  | w_ld2;

  assign bus.in_ready  = w_ld1;
  assign bus.out_valid = r_out_v;
  assign bus.q         = r_q;
  assign bus.div_zero  = r_dz;

  // S1: leading-one detect and log encode
  log_t w_la;
  log_t w_lb;
  logic w_za;
  logic w_zb;

  lod16 u_lod_a (.i_x(bus.a), .o_log(w_la), .o_zero(w_za));
  lod16 u_lod_b (.i_x(bus.b), .o_log(w_lb), .o_zero(w_zb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (w_ld1) begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) r_s1 <= '{la: w_la, lb: w_lb, za: w_za, zb: w_zb};
    end
  end

  // S2: fraction subtract as fa + ~fb + 1 in a two-half carry-select adder
  logic [WIDTH-1:0]      w_x;
  logic [WIDTH-1:0]      w_y;
  logic [HALF:0]         w_lo;
  logic [HALF:0]         w_hi0;
  logic [HALF:0]         w_hi1;
  logic [HALF:0]         w_hi;
  logic [WIDTH-1:0]      w_d;
  logic                  w_ge;
  logic signed [E_W-1:0] w_ediff;
  logic signed [E_W-1:0] w_e2;
  logic [M_W-1:0]        w_m2;

  always_comb begin
    w_x     = {1'b0, r_s1.la.f};
    w_y     = ~{1'b0, r_s1.lb.f};
    w_lo    = (HALF+1)'(w_x[HALF-1:0]) + (HALF+1)'(w_y[HALF-1:0]) + (HALF+1)'(1);
    w_hi0   = (HALF+1)'(w_x[WIDTH-1:HALF]) + (HALF+1)'(w_y[WIDTH-1:HALF]);
    w_hi1   = (HALF+1)'(w_x[WIDTH-1:HALF]) + (HALF+1)'(w_y[WIDTH-1:HALF]) + (HALF+1)'(1);
    w_hi    = w_lo[HALF] ? w_hi1 : w_hi0;
    w_d     = {w_hi[HALF-1:0], w_lo[HALF-1:0]};
    w_ge    = w_hi[HALF];
    w_ediff = E_W'(r_s1.la.k) - E_W'(r_s1.lb.k);
    // borrow: mantissa becomes 2+fa-fb (already the 16-bit wrapped difference), exponent drops by one
    if (w_ge) begin
      w_m2 = {2'b01, w_d[FRAC_W-1:0]};
      w_e2 = w_ediff;
    end else begin
      w_m2 = {1'b0, w_d};
      w_e2 = w_ediff - 5'sd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_s2   <= '0;
    end else if (w_ld2) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) r_s2 <= '{e: w_e2, m: w_m2, za: r_s1.za, zb: r_s1.zb};
    end
  end

  // S3: antilog shift into Q16.8 with defensive saturation
  logic signed [E_W-1:0] w_e3;
  logic [E_W-1:0]        w_lsh;
  logic [E_W-1:0]        w_rsh;
  logic [W_W-1:0]        w_wide;
  quo_t                  w_q3;
  logic                  w_dz3;
`ifdef LOGDIV_ROUND_EN
  logic [31:0]           w_mx;
`endif

  always_comb begin
    w_e3   = r_s2.e;
    w_lsh  = '0;
    w_rsh  = '0;
    w_wide = '0;
    w_q3   = '0;
    w_dz3  = 1'b0;
`ifdef LOGDIV_ROUND_EN
    w_mx   = 32'(r_s2.m);
`endif
    // mantissa carries 15 fraction bits, output 8: net shift is e-7
    if (w_e3 > 5'sd7) begin
      w_lsh  = E_W'(w_e3 - 5'sd7);
      w_wide = W_W'(r_s2.m) << w_lsh;
    end else begin
      w_rsh  = E_W'(5'sd7 - w_e3);
      w_wide = W_W'(r_s2.m >> w_rsh);
`ifdef LOGDIV_ROUND_EN
      if (w_rsh != '0) w_wide = w_wide + W_W'(w_mx[w_rsh - E_W'(1)]);
`endif
    end
    if (|w_wide[W_W-1:Q_W]) w_q3 = Q_SAT;
    else                    w_q3 = w_wide[Q_W-1:0];
    if (r_s2.zb) begin
      w_q3  = Q_SAT;
      w_dz3 = 1'b1;
    end else if (r_s2.za) begin
      w_q3  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_q     <= '0;
      r_dz    <= 1'b0;
    end else if (w_ld3) begin
      r_out_v <= r_s2_v;
      if (r_s2_v) begin
        r_q  <= w_q3;
        r_dz <= w_dz3;
      end
    end
  end

endmodule
